windowed_watchdog_multi: RTL and testbench
==========================================

Name: windowed_watchdog_multi

Overview:
Multi-channel windowed watchdog; parametrised successor to the single-channel window watchdog.
- Each channel supervises one client.
- A kick that arrives too early or too late raises a sticky, per-channel fault with a cause code.
- Faults persist until the supervisor clears them.
- A shared prescaler sets the time base, so long windows fit in narrow counters.
- Sits between client FSMs and the system fault/reset controller.

Parameters:
N_CH, 4, number of independent channels (>=1)
CNT_W, 8, per-channel counter width in bits
WIN_MIN, 10, lowest counter value at which a kick is accepted; 0 disables early detection
WIN_MAX, 20, counter value at which a late fault fires; require WIN_MIN <= WIN_MAX < 2**CNT_W
PRESCALE, 1, clock cycles per counter tick (>=1; 1 = tick every cycle)
WARN_MARGIN, 4, pre-timeout margin in ticks (optional feature only; < WIN_MAX)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
enable  in  N_CH  per-channel enable, level
kick  in  N_CH  per-channel kick, single-cycle pulse
clear  in  N_CH  per-channel fault clear, single-cycle pulse
fault  out  N_CH  sticky fault flag per channel
cause  out  2*N_CH  per-channel cause, bits [2i+1:2i]: 00 none, 01 early, 10 late
timeout_any  out  1  OR of all fault bits (combinational from the fault registers)
warn  out  N_CH  pre-timeout warning (see Optional Feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all counters 0, prescaler 0, every channel in DISABLED, fault=0, cause=00, warn=0, timeout_any=0.
- Prescaler: free-running from 0 to PRESCALE-1. tick=1 in the cycle where prescaler==PRESCALE-1. With PRESCALE=1, tick is constantly 1.
- Per-channel FSM: DISABLED, RUN, FAULT. All outputs are registered; an event on edge k is visible after edge k.
- DISABLED: counter held at 0; kick and clear are ignored. enable=1 -> RUN with counter 0.
- RUN, enable=0 -> DISABLED, counter 0, no fault.
- RUN, kick with counter < WIN_MIN -> FAULT, cause=01, counter frozen.
- RUN, kick with counter >= WIN_MIN -> counter 0, stay in RUN.
- RUN, no kick, tick, counter==WIN_MAX -> FAULT, cause=10, counter frozen at WIN_MAX.
- RUN, no kick, tick, counter<WIN_MAX -> counter+1. Without a tick, the counter holds.
- Priority in RUN: enable=0 > kick > tick.
- FAULT: fault=1. Kick, tick and enable are ignored. Fault survives enable deassertion.
- FAULT, clear=1 -> counter 0, cause=00, fault=0. Next state is RUN if enable=1, else DISABLED.
- clear and kick in the same cycle: clear wins and the kick is discarded.
- clear in RUN or DISABLED has no effect.
- Counter never wraps: it stops at WIN_MAX via FAULT.
- Channels are fully independent; only the prescaler is shared.
- Reset asserted mid-operation: every channel returns to the reset state on that edge, overriding all other inputs.

Optional Feature:
Macro WDT_PRETIMEOUT_EN.
- Defined: warn[i]=1 while channel i is in RUN and counter >= WIN_MAX-WARN_MARGIN.
  - Registered; deasserts on the same edge the counter is reloaded to 0 or the channel leaves RUN.
  - Never high in FAULT or DISABLED.
- Undefined: warn is tied to 0 and no comparator logic is generated; the port list is unchanged.

Test Plan:
1. Defaults, enable[0]=1, kick[0] when counter==5 -> next cycle fault[0]=1, cause[1:0]=01, timeout_any=1; other channels unaffected.
2. Defaults, enable[1]=1, no kicks -> fault[1]=1, cause[3:2]=10, 21 cycles after entering RUN; counter stays at 20; extra kicks are ignored.
3. Defaults, kick[2] at counter==12, repeated 5 times -> counter returns to 0 each time, fault[2] never asserts. Also kick at exactly counter==10 -> accepted.
4. Channel 0 in FAULT, clear[0] and kick[0] in the same cycle with enable[0]=1 -> fault[0]=0, cause=00, RUN with counter 0. Next kick at counter 3 -> early fault.
5. PRESCALE=4, no kicks -> late fault 81 to 84 cycles after entering RUN, depending on prescaler phase. Reset asserted mid-count at counter 7 -> all outputs 0, channel DISABLED.
6. WDT_PRETIMEOUT_EN defined, defaults -> warn[3] rises when counter reaches 16 and falls on an accepted kick. Undefined -> warn stays 0 throughout scenario 2.

Source files
------------

// File: rtl/windowed_watchdog_multi.sv
// Multi-channel windowed watchdog with a shared prescaler and sticky per-channel fault/cause.
// Optional pre-timeout warning is built when WDT_PRETIMEOUT_EN is defined; otherwise warn is tied low.
module windowed_watchdog_multi #(
   parameter int N_CH        = 4,
   parameter int CNT_W       = 8,
   parameter int WIN_MIN     = 10,
   parameter int WIN_MAX     = 20,
   parameter int PRESCALE    = 1,
   parameter int WARN_MARGIN = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_CH-1:0]     enable,
   input  logic [N_CH-1:0]     kick,
   input  logic [N_CH-1:0]     clear,
   output logic [N_CH-1:0]     fault,
   output logic [2*N_CH-1:0]   cause,
   output logic                timeout_any,
   output logic [N_CH-1:0]     warn
);

   typedef enum logic [1:0] {
      ST_DISABLED = 2'b00,
      ST_RUN      = 2'b01,
      ST_FAULT    = 2'b10
   } state_t;

   localparam logic [1:0]       CAUSE_NONE  = 2'b00;
   localparam logic [1:0]       CAUSE_EARLY = 2'b01;
   localparam logic [1:0]       CAUSE_LATE  = 2'b10;
   localparam logic [CNT_W-1:0] WIN_MIN_C   = CNT_W'(WIN_MIN);
   localparam logic [CNT_W-1:0] WIN_MAX_C   = CNT_W'(WIN_MAX);

   if (N_CH < 1 || PRESCALE < 1 || WIN_MIN > WIN_MAX || WIN_MAX >= (1 << CNT_W) ||
       WARN_MARGIN >= WIN_MAX) begin : g_param_check
      $error("windowed_watchdog_multi: illegal parameter set");
   end

   logic tick_s;

   if (PRESCALE > 1) begin : g_ps
      localparam int             PS_W    = $clog2(PRESCALE);
      localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
      logic [PS_W-1:0] ps_r;

      // Free-running time-base divider shared by all channels
      always_ff @(posedge clk) begin
         if (reset) begin
            ps_r <= '0;
         end else if (ps_r == PS_LAST) begin
            ps_r <= '0;
         end else begin
            ps_r <= ps_r + PS_W'(1);
         end
      end

      assign tick_s = (ps_r == PS_LAST);
   end else begin : g_no_ps
      assign tick_s = 1'b1;
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      state_t           state_r, state_s;
      logic [CNT_W-1:0] cnt_r, cnt_s;
      logic [1:0]       cause_r, cause_s;
      logic             fault_r;

      // Channel next-state: enable=0 beats kick beats tick; clear only acts in FAULT
      always_comb begin
         state_s = state_r;
         cnt_s   = cnt_r;
         cause_s = cause_r;
         case (state_r)
            ST_DISABLED: begin
               cnt_s   = '0;
               cause_s = CAUSE_NONE;
               if (enable[i]) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_DISABLED;
               end
            end
            ST_RUN: begin
               if (!enable[i]) begin
                  state_s = ST_DISABLED;
                  cnt_s   = '0;
               end else if (kick[i]) begin
                  if (cnt_r < WIN_MIN_C) begin
                     state_s = ST_FAULT;
                     cause_s = CAUSE_EARLY;
                  end else begin
                     cnt_s = '0;
                  end
               end else if (tick_s) begin
                  if (cnt_r == WIN_MAX_C) begin
                     state_s = ST_FAULT;
                     cause_s = CAUSE_LATE;
                  end else begin
                     cnt_s = cnt_r + CNT_W'(1);
                  end
               end else begin
                  cnt_s = cnt_r;
               end
            end
            ST_FAULT: begin
               if (clear[i]) begin
                  cnt_s   = '0;
                  cause_s = CAUSE_NONE;
                  if (enable[i]) begin
                     state_s = ST_RUN;
                  end else begin
                     state_s = ST_DISABLED;
                  end
               end else begin
                  state_s = ST_FAULT;
               end
            end
            default: begin
               state_s = ST_DISABLED;
               cnt_s   = '0;
               cause_s = CAUSE_NONE;
            end
         endcase
      end

      // Channel state, counter and registered fault/cause
      always_ff @(posedge clk) begin
         if (reset) begin
            state_r <= ST_DISABLED;
            cnt_r   <= '0;
            cause_r <= CAUSE_NONE;
            fault_r <= 1'b0;
         end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            cause_r <= cause_s;
            fault_r <= (state_s == ST_FAULT);
         end
      end

`ifdef WDT_PRETIMEOUT_EN
      localparam logic [CNT_W-1:0] WARN_TH_C = CNT_W'(WIN_MAX - WARN_MARGIN);
      logic warn_r;

      // Warning follows the next counter value so it drops on the reload/exit edge
      always_ff @(posedge clk) begin
         if (reset) begin
            warn_r <= 1'b0;
         end else begin
            warn_r <= (state_s == ST_RUN) && (cnt_s >= WARN_TH_C);
         end
      end

      assign warn[i] = warn_r;
`else
      assign warn[i] = 1'b0;
`endif

      assign fault[i]           = fault_r;
      assign cause[2*i +: 2]    = cause_r;
   end

   assign timeout_any = |fault;

endmodule

// File: tb/tb_windowed_watchdog_multi.sv
// Directed bench for windowed_watchdog_multi: default instance plus a PRESCALE=4 instance.
module tb_windowed_watchdog_multi;

`ifdef WDT_PRETIMEOUT_EN
   localparam bit PRE_EN = 1'b1;
`else
   localparam bit PRE_EN = 1'b0;
`endif

   logic       clk;
   logic       rst, rst_p;
   logic [3:0] en, kk, cl, fault, warn;
   logic [7:0] cause;
   logic       tany;
   logic [3:0] en_p, kk_p, cl_p, fault_p, warn_p;
   logic [7:0] cause_p;
   logic       tany_p;

   int checks   = 0;
   int failures = 0;

   windowed_watchdog_multi u_dut (
      .clk(clk), .reset(rst), .enable(en), .kick(kk), .clear(cl),
      .fault(fault), .cause(cause), .timeout_any(tany), .warn(warn)
   );

   windowed_watchdog_multi #(.PRESCALE(4)) u_dut_ps (
      .clk(clk), .reset(rst_p), .enable(en_p), .kick(kk_p), .clear(cl_p),
      .fault(fault_p), .cause(cause_p), .timeout_any(tany_p), .warn(warn_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       kick;
      logic       clr;
      logic       exp_fault;
      logic [1:0] exp_cause;
   } vec_t;

   vec_t vecs[20];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int  n;
      bit  seen;

      // channel 0 table: entry, early kick at 5, clear+kick, early at 3, disabled ignores
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      for (int i = 1; i <= 5; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
      vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

      rst = 1'b1; rst_p = 1'b1;
      en = 4'b0; kk = 4'b0; cl = 4'b0;
      en_p = 4'b0; kk_p = 4'b0; cl_p = 4'b0;
      step(); step();
      chk("reset_fault", 32'(fault), 32'h0);
      chk("reset_cause", 32'(cause), 32'h0);
      chk("reset_any", 32'(tany), 32'h0);
      chk("reset_warn", 32'(warn), 32'h0);
      chk("reset_ps_fault", 32'(fault_p), 32'h0);
      rst = 1'b0; rst_p = 1'b0;
      step();

      // scenario 1/4: table on channel 0
      for (int i = 0; i < 20; i++) begin
         en[0] = vecs[i].en; kk[0] = vecs[i].kick; cl[0] = vecs[i].clr;
         step();
         chk($sformatf("tbl%0d_fault", i), 32'(fault[0]), 32'(vecs[i].exp_fault));
         chk($sformatf("tbl%0d_cause", i), 32'(cause[1:0]), 32'(vecs[i].exp_cause));
         chk($sformatf("tbl%0d_any", i), 32'(tany), 32'(vecs[i].exp_fault));
         chk($sformatf("tbl%0d_others", i), 32'(fault[3:1]), 32'h0);
      end
      kk[0] = 1'b0; cl[0] = 1'b0;

      // scenario 2: late fault on channel 1 after 21 cycles, kicks ignored
      en[1] = 1'b1;
      step();
      n = 0; seen = 1'b0;
      while (!fault[1] && n < 40) begin
         step();
         n++;
         if (warn[1]) seen = 1'b1;
      end
      chk("late_latency", 32'(n), 32'd21);
      chk("late_cause", 32'(cause[3:2]), 32'h2);
      chk("late_any", 32'(tany), 32'h1);
      for (int k = 0; k < 3; k++) begin
         kk[1] = 1'b1; step(); kk[1] = 1'b0; step();
         chk("late_kick_ignored", 32'(fault[1]), 32'h1);
         chk("late_kick_cause", 32'(cause[3:2]), 32'h2);
      end
      chk("late_warn_seen", 32'(seen), 32'(PRE_EN));
      chk("late_warn_in_fault", 32'(warn[1]), 32'h0);
      en[1] = 1'b0; cl[1] = 1'b1; step(); cl[1] = 1'b0;
      chk("late_clear_disabled", 32'(fault[1]), 32'h0);
      chk("late_clear_cause", 32'(cause[3:2]), 32'h0);

      // scenario 3: repeated in-window kicks on channel 2
      en[2] = 1'b1;
      step();
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         repeat (12) step();
         kk[2] = 1'b1; step(); kk[2] = 1'b0;
         if (fault[2]) seen = 1'b1;
      end
      chk("window_kicks_no_fault", 32'(seen), 32'h0);
      repeat (10) step();
      kk[2] = 1'b1; step(); kk[2] = 1'b0;
      chk("kick_at_win_min", 32'(fault[2]), 32'h0);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (fault[2]) seen = 1'b1;
      end
      chk("reload_no_fault_20", 32'(seen), 32'h0);
      step();
      chk("reload_fault_21", 32'(fault[2]), 32'h1);
      chk("reload_fault_cause", 32'(cause[5:4]), 32'h2);
      cl[2] = 1'b1; step(); cl[2] = 1'b0;
      chk("clear_to_run", 32'(fault[2]), 32'h0);
      repeat (9) step();
      kk[2] = 1'b1; step(); kk[2] = 1'b0;
      chk("kick_at_9_early", 32'(fault[2]), 32'h1);
      chk("kick_at_9_cause", 32'(cause[5:4]), 32'h1);
      en[2] = 1'b0; cl[2] = 1'b1; step(); cl[2] = 1'b0;
      chk("ch2_cleared", 32'(fault[2]), 32'h0);

      // scenario 6: pre-timeout warning on channel 3
      en[3] = 1'b1;
      step();
      repeat (15) step();
      chk("warn_cnt15", 32'(warn[3]), 32'h0);
      step();
      chk("warn_cnt16", 32'(warn[3]), 32'(PRE_EN));
      step();
      chk("warn_cnt17", 32'(warn[3]), 32'(PRE_EN));
      kk[3] = 1'b1; step(); kk[3] = 1'b0;
      chk("warn_after_kick", 32'(warn[3]), 32'h0);
      chk("warn_kick_no_fault", 32'(fault[3]), 32'h0);
      en[3] = 1'b0; step();
      chk("warn_disabled", 32'(warn[3]), 32'h0);

      // scenario 5: prescaled instance
      en_p[0] = 1'b1;
      step();
      n = 0;
      while (!fault_p[0] && n < 120) begin
         step();
         n++;
      end
      chk("ps_late_window", 32'(n >= 81 && n <= 84), 32'h1);
      chk("ps_late_cause", 32'(cause_p[1:0]), 32'h2);
      chk("ps_late_any", 32'(tany_p), 32'h1);
      cl_p[0] = 1'b1; step(); cl_p[0] = 1'b0;
      chk("ps_clear", 32'(fault_p[0]), 32'h0);
      repeat (30) step();
      chk("ps_midcount_no_fault", 32'(fault_p[0]), 32'h0);
      rst_p = 1'b1; step();
      chk("ps_reset_fault", 32'(fault_p), 32'h0);
      chk("ps_reset_cause", 32'(cause_p), 32'h0);
      chk("ps_reset_any", 32'(tany_p), 32'h0);
      chk("ps_reset_warn", 32'(warn_p), 32'h0);
      rst_p = 1'b0;
      step();
      n = 0;
      while (!fault_p[0] && n < 120) begin
         step();
         n++;
      end
      chk("ps_late_from_reset", 32'(n), 32'd83);

      // reset overrides an active fault and enable
      en[0] = 1'b1; step();
      kk[0] = 1'b1; step(); kk[0] = 1'b0;
      chk("pre_reset_any", 32'(tany), 32'h1);
      rst = 1'b1; step();
      chk("midreset_fault", 32'(fault), 32'h0);
      chk("midreset_cause", 32'(cause), 32'h0);
      chk("midreset_any", 32'(tany), 32'h0);
      rst = 1'b0; en[0] = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
